folded_sum_reducer: RTL and testbench
=====================================

Name: folded_sum_reducer

Overview:
- Parametrised multi-cycle reduction adder: sums NUM_IN operands of IN_W bits using only NUM_ADD physical adders, folded over several cycles.
- Generalises the fixed 30-input, 6-adder summing stage into a block with configurable operand count, width and adder count.
- Adds a start/ready/valid handshake and a deterministic, documented latency.
- Sits between a parallel operand source (e.g. a window or tap register bank) and downstream accumulate/compare logic.

Parameters:
- NUM_IN, 30, number of operands; must be >= 1.
- IN_W, 8, operand width in bits.
- NUM_ADD, 6, adders available per cycle; must be >= 1.
- OUT_W, IN_W+$clog2(NUM_IN), result width. Derived localparam, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only when in_ready=1.
- in_data  input  NUM_IN*IN_W  flattened operands; operand k is in_data[k*IN_W +: IN_W].
- in_ready  output  1  high in IDLE only.
- out_valid  output  1  one-cycle pulse when sum_out is updated.
- sum_out  output  OUT_W  result; held until the next result.
- busy  output  1  inverse of in_ready.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, cnt=0, out_valid=0, sum_out=0, in_ready=1, busy=0.
  - Working buffer contents are don't-care.
  - Reset mid-operation aborts the operation; no out_valid is produced for it.
- Internal storage: working buffer buf[0..NUM_IN-1], each entry OUT_W bits, plus count cnt.
- States: IDLE, REDUCE.
- IDLE:
  - On start=1, capture all operands, zero-extended to OUT_W, into buf[k]=operand k.
  - Set cnt=NUM_IN and go to REDUCE.
- REDUCE, each edge with cnt>1 (one reduction step):
  - p = min(NUM_ADD, floor(cnt/2)).
  - sums s[j] = buf[2j] + buf[2j+1] for j=0..p-1.
  - New buffer = old entries 2p..cnt-1 moved to the front, followed by s[0..p-1].
  - cnt_next = cnt-p.
- REDUCE, edge with cnt==1:
  - sum_out <= buf[0], out_valid <= 1, go to IDLE.
- Latency:
  - R = number of reduction steps needed to take NUM_IN to 1.
  - out_valid is high on the (R+1)-th edge after the start-capture edge.
  - Defaults: cnt sequence 30,24,18,12,6,3,2,1, so R=7; out_valid at edge 8.
  - NUM_IN=1: R=0, out_valid at edge 1.
- start while busy: ignored, no queuing.
- start in the cycle out_valid is high: accepted, because state is already IDLE. This gives back-to-back operation.
- Arithmetic:
  - Unsigned, full precision; OUT_W guarantees no overflow.
  - Reduction order is fixed as above, so results are bit-exact and deterministic.
- in_data is only sampled at the capture edge; changes while busy have no effect.
- out_valid is deasserted on every edge other than the completing one.

Optional Feature:
- Macro: FOLD_SIGNED_EN.
- Defined: operands are two's complement and sign-extended to OUT_W at capture; sum_out is a two's complement result. Latency is unchanged.
- Undefined: operands are unsigned and zero-extended, as described in Behaviour.

Test Plan:
- Defaults, operand k=k (0..29), pulse start -> out_valid at edge 8 after capture, sum_out=435, exactly one pulse.
- Defaults, all operands 255 -> sum_out=7650 (13-bit, no overflow); then immediate start with all 1 in the out_valid cycle -> accepted, second result 30 after 8 further edges.
- Defaults, start re-pulsed on edges 2-6 with different data -> ignored; result matches first capture; in_ready=0 throughout.
- Defaults, rst=0 at edge 4 of an operation -> out_valid never pulses, sum_out=0, in_ready=1 the next cycle; new start completes normally.
- NUM_IN=5, NUM_ADD=1, IN_W=4, operands 15,15,15,15,15 -> cnt 5,4,3,2,1, out_valid at edge 5, sum_out=75 (OUT_W=7).
- FOLD_SIGNED_EN defined, defaults, all operands 8'hFF -> sum_out = -30 = 13'h1FE2.

Source files
------------

// File: rtl/folded_sum_reducer.sv
// folded_sum_reducer: sums NUM_IN operands of IN_W bits using NUM_ADD adders,
// folded over several cycles behind a start/ready/valid handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   start      request, sampled only while in_ready is high
//   in_data    flattened operands; operand k is in_data[k*IN_W +: IN_W]
//   in_ready   high while idle
//   out_valid  one-cycle pulse when sum_out is updated
//   sum_out    result, held until the next result
//   busy       inverse of in_ready
//
// Optional feature: define FOLD_SIGNED_EN to treat operands as two's complement
// (sign-extended at capture). Default build is unsigned (zero-extended).
//
// Latency: out_valid rises on the (R+1)-th edge after the capture edge, where R
// is the number of reduction steps needed to take NUM_IN down to 1.

module folded_sum_reducer #(
    parameter int unsigned NUM_IN  = 30,
    parameter int unsigned IN_W    = 8,
    parameter int unsigned NUM_ADD = 6,
    localparam int unsigned OUT_W  = IN_W + $clog2(NUM_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [OUT_W-1:0]       sum_out,
    output logic                   busy
);

    localparam int unsigned CNT_W  = $clog2(NUM_IN + 1);
    localparam int unsigned IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned SIDX_W = (NUM_ADD > 1) ? $clog2(NUM_ADD) : 1;

    typedef enum logic {
        IDLE,
        REDUCE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   work_q [NUM_IN];
    logic [OUT_W-1:0]   work_d [NUM_IN];
    logic [OUT_W-1:0]   sum_q, sum_d;
    logic               valid_q, valid_d;
    logic               ready_q, busy_q;

    logic [CNT_W-1:0]   pairs, p, keep;
    logic [OUT_W-1:0]   sums [NUM_ADD];

    // Adders used this step: min(NUM_ADD, cnt/2); entries left unpaired: cnt-2p.
    assign pairs = cnt_q >> 1;
    assign p     = (32'(pairs) > NUM_ADD) ? CNT_W'(NUM_ADD) : pairs;
    assign keep  = CNT_W'(cnt_q - (p << 1));

    // Physical adders, always paired on the front of the buffer.
    for (genvar j = 0; j < NUM_ADD; j++) begin : g_add
        if (2 * j + 1 < NUM_IN) begin : g_pair
            assign sums[j] = work_q[2*j] + work_q[2*j+1];
        end else begin : g_none
            assign sums[j] = '0;
        end
    end

    // Next-state, buffer update and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        sum_d   = sum_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned k = 0; k < NUM_IN; k++) begin
`ifdef FOLD_SIGNED_EN
                        work_d[k] = OUT_W'($signed(in_data[k*IN_W +: IN_W]));
`else
                        work_d[k] = OUT_W'(in_data[k*IN_W +: IN_W]);
`endif
                    end
                    cnt_d   = CNT_W'(NUM_IN);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (cnt_q > CNT_W'(1)) begin
                    // Unpaired tail moves to the front, new sums are appended.
                    for (int unsigned i = 0; i < NUM_IN; i++) begin
                        if (i < 32'(keep)) begin
                            work_d[i] = work_q[IDX_W'(i + (32'(p) << 1))];
                        end else if (i < 32'(cnt_q - p)) begin
                            work_d[i] = sums[SIDX_W'(i - 32'(keep))];
                        end
                    end
                    cnt_d = CNT_W'(cnt_q - p);
                end else begin
                    sum_d   = work_q[0];
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
        end
    end

    // Working buffer needs no reset; it is fully loaded at capture.
    always_ff @(posedge clk) begin
        work_q <= work_d;
    end

    assign in_ready  = ready_q;
    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_folded_sum_reducer.sv
// Scoreboard bench for folded_sum_reducer: default instance plus a small
// NUM_IN=5 / NUM_ADD=1 / IN_W=4 instance. Honors FOLD_SIGNED_EN.

module tb_folded_sum_reducer;

    localparam int unsigned NUM_IN  = 30;
    localparam int unsigned IN_W    = 8;
    localparam int unsigned NUM_ADD = 6;
    localparam int unsigned OUT_W   = 13;

    localparam int unsigned S_NUM_IN  = 5;
    localparam int unsigned S_IN_W    = 4;
    localparam int unsigned S_NUM_ADD = 1;
    localparam int unsigned S_OUT_W   = 7;

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic [NUM_IN*IN_W-1:0]     in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic [OUT_W-1:0]           sum_out;
    logic                       busy;

    logic                       s_start;
    logic [S_NUM_IN*S_IN_W-1:0] s_in_data;
    logic                       s_in_ready;
    logic                       s_out_valid;
    logic [S_OUT_W-1:0]         s_sum_out;
    logic                       s_busy;

    logic [OUT_W-1:0]   sb   [$];
    logic [S_OUT_W-1:0] sb_s [$];

    int tests_run = 0;
    int fails     = 0;

    folded_sum_reducer #(
        .NUM_IN (NUM_IN),
        .IN_W   (IN_W),
        .NUM_ADD(NUM_ADD)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .sum_out  (sum_out),
        .busy     (busy)
    );

    folded_sum_reducer #(
        .NUM_IN (S_NUM_IN),
        .IN_W   (S_IN_W),
        .NUM_ADD(S_NUM_ADD)
    ) u_small (
        .clk      (clk),
        .rst      (rst),
        .start    (s_start),
        .in_data  (s_in_data),
        .in_ready (s_in_ready),
        .out_valid(s_out_valid),
        .sum_out  (s_sum_out),
        .busy     (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [OUT_W-1:0] ref_sum(input logic [NUM_IN*IN_W-1:0] d);
        logic [OUT_W-1:0] acc = '0;
        for (int k = 0; k < NUM_IN; k++) begin
`ifdef FOLD_SIGNED_EN
            acc += OUT_W'($signed(d[k*IN_W +: IN_W]));
`else
            acc += OUT_W'(d[k*IN_W +: IN_W]);
`endif
        end
        return acc;
    endfunction

    function automatic logic [S_OUT_W-1:0] ref_sum_s(input logic [S_NUM_IN*S_IN_W-1:0] d);
        logic [S_OUT_W-1:0] acc = '0;
        for (int k = 0; k < S_NUM_IN; k++) begin
`ifdef FOLD_SIGNED_EN
            acc += S_OUT_W'($signed(d[k*S_IN_W +: S_IN_W]));
`else
            acc += S_OUT_W'(d[k*S_IN_W +: S_IN_W]);
`endif
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until out_valid, bounded; returns edges elapsed.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic wait_valid_s(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_out_valid && n < 40);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        s_start = 1'b0;
        in_data = '0;
        s_in_data = '0;
        tick();
        tick();
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++;
        if (sum_out !== '0) begin fails++; $display("FAIL reset_sum_out: got %0d expected 0", sum_out); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [NUM_IN*IN_W-1:0] d;
        logic [OUT_W-1:0] exp;
        int n;
        for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'(k);
        sb.push_back(OUT_W'(435));
        start = 1'b1;
        in_data = d;
        tick();
        start = 1'b0;
        wait_valid(n);
        tests_run++;
        if (n !== 8) begin fails++; $display("FAIL seq_latency: got %0d edges expected 8", n); end
        exp = sb.pop_front();
        tests_run++;
        if (sum_out !== exp) begin fails++; $display("FAIL seq_sum: got %0d expected %0d", sum_out, exp); end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL seq_single_pulse: got %b expected 0", out_valid); end
        tests_run++;
        if (sum_out !== exp) begin fails++; $display("FAIL seq_hold: got %0d expected %0d", sum_out, exp); end
    endtask

    task automatic test_back_to_back();
        logic [NUM_IN*IN_W-1:0] d;
        logic [OUT_W-1:0] exp;
        int n;
`ifdef FOLD_SIGNED_EN
        sb.push_back(13'h1FE2);
`else
        sb.push_back(OUT_W'(7650));
`endif
        start = 1'b1;
        in_data = '1;
        tick();
        start = 1'b0;
        wait_valid(n);
        tests_run++;
        if (n !== 8) begin fails++; $display("FAIL b2b_latency1: got %0d edges expected 8", n); end
        exp = sb.pop_front();
        tests_run++;
        if (sum_out !== exp) begin fails++; $display("FAIL b2b_sum1: got %0h expected %0h", sum_out, exp); end
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_at_valid: got %b expected 1", in_ready); end
        for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'(1);
        sb.push_back(OUT_W'(30));
        start = 1'b1;
        in_data = d;
        tick();
        start = 1'b0;
        wait_valid(n);
        tests_run++;
        if (n !== 8) begin fails++; $display("FAIL b2b_latency2: got %0d edges expected 8", n); end
        exp = sb.pop_front();
        tests_run++;
        if (sum_out !== exp) begin fails++; $display("FAIL b2b_sum2: got %0d expected %0d", sum_out, exp); end
    endtask

    task automatic test_busy_ignore();
        logic [NUM_IN*IN_W-1:0] d;
        logic [OUT_W-1:0] exp;
        for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
        sb.push_back(ref_sum(d));
        start = 1'b1;
        in_data = d;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            if (e >= 2 && e <= 6) begin
                start = 1'b1;
                for (int k = 0; k < NUM_IN; k++) in_data[k*IN_W +: IN_W] = IN_W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            tests_run++;
            if ({in_ready, busy, out_valid} !== 3'b010) begin
                fails++;
                $display("FAIL busy_flags edge %0d: got ready/busy/valid=%b expected 010", e, {in_ready, busy, out_valid});
            end
        end
        start = 1'b0;
        tick();
        tests_run++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL busy_valid_edge8: got %b expected 1", out_valid); end
        exp = sb.pop_front();
        tests_run++;
        if (sum_out !== exp) begin fails++; $display("FAIL busy_sum: got %0d expected %0d", sum_out, exp); end
    endtask

    task automatic test_reset_mid();
        logic [NUM_IN*IN_W-1:0] d;
        logic [OUT_W-1:0] exp;
        int n;
        int seen;
        for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
        sb.push_back(ref_sum(d));
        start = 1'b1;
        in_data = d;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sb.delete();
        tests_run++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL midrst_flags: got valid/ready/busy=%b expected 010", {out_valid, in_ready, busy});
        end
        tests_run++;
        if (sum_out !== '0) begin fails++; $display("FAIL midrst_sum: got %0d expected 0", sum_out); end
        seen = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (out_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin fails++; $display("FAIL midrst_no_pulse: got %0d pulses expected 0", seen); end
        for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
        sb.push_back(ref_sum(d));
        start = 1'b1;
        in_data = d;
        tick();
        start = 1'b0;
        wait_valid(n);
        tests_run++;
        if (n !== 8) begin fails++; $display("FAIL midrst_latency: got %0d edges expected 8", n); end
        exp = sb.pop_front();
        tests_run++;
        if (sum_out !== exp) begin fails++; $display("FAIL midrst_sum_after: got %0d expected %0d", sum_out, exp); end
    endtask

    task automatic test_random();
        logic [NUM_IN*IN_W-1:0] d;
        logic [OUT_W-1:0] exp;
        int n;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
            sb.push_back(ref_sum(d));
            start = 1'b1;
            in_data = d;
            tick();
            start = 1'b0;
            wait_valid(n);
            tests_run++;
            if (n !== 8) begin fails++; $display("FAIL rand_latency[%0d]: got %0d edges expected 8", r, n); end
            exp = sb.pop_front();
            tests_run++;
            if (sum_out !== exp) begin fails++; $display("FAIL rand_sum[%0d]: got %0h expected %0h", r, sum_out, exp); end
        end
    endtask

    task automatic test_small();
        logic [S_NUM_IN*S_IN_W-1:0] d;
        logic [S_OUT_W-1:0] exp;
        int n;
        for (int r = 0; r < 4; r++) begin
            if (r == 0) begin
                d = '1;
`ifdef FOLD_SIGNED_EN
                sb_s.push_back(7'h7B);
`else
                sb_s.push_back(S_OUT_W'(75));
`endif
            end else begin
                for (int k = 0; k < S_NUM_IN; k++) d[k*S_IN_W +: S_IN_W] = S_IN_W'($urandom);
                sb_s.push_back(ref_sum_s(d));
            end
            s_start = 1'b1;
            s_in_data = d;
            tick();
            s_start = 1'b0;
            wait_valid_s(n);
            tests_run++;
            if (n !== 5) begin fails++; $display("FAIL small_latency[%0d]: got %0d edges expected 5", r, n); end
            exp = sb_s.pop_front();
            tests_run++;
            if (s_sum_out !== exp) begin fails++; $display("FAIL small_sum[%0d]: got %0h expected %0h", r, s_sum_out, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_back_to_back();
        tick();
        test_busy_ignore();
        tick();
        test_reset_mid();
        tick();
        test_random();
        tick();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
